mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Single-port synchronous memory controller with a request /
//               response handshake and a configurable read latency.
//               Define MEM_CTRL_INIT_EN to zero-fill the array after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int DW     = 64,
    parameter int AW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
`ifdef MEM_CTRL_INIT_EN
        , ST_INIT = 3'd5
`endif
    } state_t;

`ifdef MEM_CTRL_INIT_EN
    localparam state_t        c_reset_state = ST_INIT;
    localparam logic [AW-1:0] c_addr_max    = '1;
`else
    localparam state_t        c_reset_state = ST_IDLE;
`endif
    // WAIT covers the remaining memory pipeline stages plus the sampling cycle
    localparam logic [1:0]    c_wait_load   = 2'(RD_LAT - 1);

    state_t        r_state;
    logic [1:0]    r_wait_cnt;
`ifdef MEM_CTRL_INIT_EN
    logic [AW-1:0] r_init_addr;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_reset_state;
            r_wait_cnt  <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mem_mode    <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
`ifdef MEM_CTRL_INIT_EN
            r_init_addr <= '0;
`endif
        end else begin
            case (r_state)
`ifdef MEM_CTRL_INIT_EN
                ST_INIT: begin
                    mem_mode    <= 1'b0;
                    mem_addr    <= r_init_addr;
                    mem_wdata   <= '0;
                    r_init_addr <= r_init_addr + AW'(1);
                    if (r_init_addr == c_addr_max) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    mem_mode <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        mem_addr  <= req_addr;
                        if (req_we) begin
                            mem_mode  <= 1'b0;
                            mem_wdata <= req_wdata;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_state   <= ST_READ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    mem_mode  <= 1'b1;
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                ST_READ: begin
                    r_wait_cnt <= c_wait_load;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_reset_state;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    mem_mode  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl with a behavioural memory of
//               latency RD_LAT and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int DW     = 64;
    localparam int AW     = 5;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: writes on mem_mode=0, read data RD_LAT cycles later
    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] rd_pipe [RD_LAT];
    int unsigned   cyc = 0;
    int unsigned   wr_cnt = 0;
    int unsigned   rsp_cnt = 0;
    logic [AW-1:0] init_next = '0;
    logic          init_bad = 1'b0;
    logic          init_phase = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_mode) begin
            mem_array[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
            if (init_phase) begin
                if (mem_addr != init_next || mem_wdata != '0) init_bad <= 1'b1;
                init_next <= init_next + AW'(1);
            end
        end
        rd_pipe[0] <= mem_array[mem_addr];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    logic [DW-1:0] sb_mem [DEPTH];
    logic [DW-1:0] sb_q [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int unsigned   acc_cyc = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, DW'(req_ready), DW'(0));
        check({tag, "_rsp_valid"}, DW'(rsp_valid), DW'(0));
        check({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check({tag, "_mem_mode"}, DW'(mem_mode), DW'(1));
        check({tag, "_mem_addr"}, DW'(mem_addr), DW'(0));
        check({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", DW'(req_ready), DW'(1));
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic release_reset(input int exp_n);
        int n;
        n = 0;
        reset = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!req_ready && n < 200);
        check("ready_rise_cycles", DW'(n), DW'(exp_n));
    endtask

    task automatic write_chk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned wc0;
        wc0 = wr_cnt;
        sb_mem[a] = d;
        issue(1'b1, a, d);
        check("wr_mode_low", DW'(mem_mode), DW'(0));
        check("wr_addr", DW'(mem_addr), DW'(a));
        check("wr_data", mem_wdata, d);
        @(posedge clk); #1;
        check("wr_mode_back", DW'(mem_mode), DW'(1));
        check("wr_count", DW'(wr_cnt - wc0), DW'(1));
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input int hold, input logic early);
        int            lat;
        int unsigned   rc0;
        logic [DW-1:0] held;
        logic [DW-1:0] exp;
        lat = 0;
        rc0 = rsp_cnt;
        rsp_ready = early;
        sb_q.push_back(sb_mem[a]);
        issue(1'b0, a, '0);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", DW'(lat), DW'(RD_LAT + 1));
        held = rsp_rdata;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("bp_valid", DW'(rsp_valid), DW'(1));
                check("bp_data", rsp_rdata, held);
                check("bp_req_ready", DW'(req_ready), DW'(0));
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        exp = sb_q.pop_front();
        check("rsp_data", held, exp);
        #1;
        rsp_ready = 1'b0;
        check("rsp_drop", DW'(rsp_valid), DW'(0));
        check("rsp_count", DW'(rsp_cnt - rc0), DW'(1));
        check("ready_after_rsp", DW'(req_ready), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1);
    end

    initial begin
        int unsigned   a0;
        int unsigned   rc0;
        int unsigned   wc0;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

`ifdef MEM_CTRL_INIT_EN
        wc0 = wr_cnt;
        init_phase = 1'b1;
        release_reset(DEPTH + 1);
        init_phase = 1'b0;
        check("init_writes", DW'(wr_cnt - wc0), DW'(DEPTH));
        check("init_order", DW'(init_bad), DW'(0));
        for (int i = 0; i < DEPTH; i++) sb_mem[i] = '0;
        read_chk(AW'(17), 0, 1'b0);
`else
        release_reset(1);
`endif

        write_chk(AW'(5), 64'h0000_0000_00AB_CDEF);
        a0 = acc_cyc;
        write_chk(AW'(6), 64'h0000_0000_0012_3456);
        check("wr_throughput", DW'(acc_cyc - a0), DW'(2));
        read_chk(AW'(5), 7, 1'b0);
        read_chk(AW'(6), 0, 1'b1);
        write_chk(AW'(31), 64'hFFFF_FFFF_FFFF_FFFF);
        read_chk(AW'(31), 0, 1'b0);

        // Reset lands while the read sits in WAIT
        rc0 = rsp_cnt;
        issue(1'b0, AW'(5), '0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        wc0 = wr_cnt;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrd");
        @(posedge clk); #1;
`ifdef MEM_CTRL_INIT_EN
        init_phase = 1'b1;
        release_reset(DEPTH + 1);
        init_phase = 1'b0;
        for (int i = 0; i < DEPTH; i++) sb_mem[i] = '0;
`else
        release_reset(1);
        check("midrd_no_write", DW'(wr_cnt - wc0), DW'(0));
`endif
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("midrd_no_rsp", DW'(rsp_cnt - rc0), DW'(0));
        check("midrd_valid", DW'(rsp_valid), DW'(0));

        void'($urandom(1964));
        for (int i = 0; i < 10; i++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            rd = DW'($urandom & 32'h00FF_FFFF);
            write_chk(ra, rd);
            read_chk(ra, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
